ipid_stream_rx: RTL and testbench

//  Receiver/deserialiser for the 16-bit IPID chunk stream. Framing, in order:

---
 rtl/ipid_stream_rx.sv | 184 ++++++++++++++++++
 tb/tb_ipid_stream_rx.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/ipid_stream_rx.sv
// ipid_stream_rx: receiver/deserialiser for the 16-bit IPID chunk stream.
// A frame is START_WORD, NUM_CHUNKS data words (least-significant first) and
// STOP_WORD, with valid high on every cycle. The block rebuilds the ID_W-bit
// IP identifier, pulses ipid_done on a good frame and err on an aborted one.
//
// Optional feature macro: IPID_RX_COMPARE_EN (adds ipid_expected / ipid_match).
//
// Ports:
//   clk           in   rising-edge clock
//   rst           in   asynchronous reset, active-low
//   valid         in   stream word valid
//   ipid_chunk    in   stream word
//   ipid_expected in   reference ID (IPID_RX_COMPARE_EN only)
//   ipid_match    out  received ID equals ipid_expected (IPID_RX_COMPARE_EN only)
//   ipid_out      out  last correctly received IPID
//   ipid_done     out  one-cycle pulse, good frame received
//   ipid_locked   out  sticky, at least one good frame since reset
//   busy          out  frame in progress
//   err           out  one-cycle pulse, frame aborted
//   err_code      out  last error: 00 none, 01 gap, 10 bad stop
module ipid_stream_rx #(
  parameter int unsigned          CHUNK_W    = 16,
  parameter int unsigned          NUM_CHUNKS = 16,
  parameter logic [CHUNK_W-1:0]   START_WORD = CHUNK_W'(16'h7A7A),
  parameter logic [CHUNK_W-1:0]   STOP_WORD  = CHUNK_W'(16'hB9B9)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          valid,
  input  logic [CHUNK_W-1:0]            ipid_chunk,
`ifdef IPID_RX_COMPARE_EN
  input  logic [CHUNK_W*NUM_CHUNKS-1:0] ipid_expected,
  output logic                          ipid_match,
`endif
  output logic [CHUNK_W*NUM_CHUNKS-1:0] ipid_out,
  output logic                          ipid_done,
  output logic                          ipid_locked,
  output logic                          busy,
  output logic                          err,
  output logic [1:0]                    err_code
);

  localparam int unsigned ID_W  = CHUNK_W * NUM_CHUNKS;
  localparam int unsigned CNT_W = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_GAP  = 2'b01;
  localparam logic [1:0] ERR_STOP = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_STOP = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [ID_W-1:0]    shadow_q, shadow_d;
  logic [ID_W-1:0]    ipid_out_q, ipid_out_d;
  logic               done_q, done_d;
  logic               locked_q, locked_d;
  logic               busy_q, busy_d;
  logic               err_q, err_d;
  logic [1:0]         err_code_q, err_code_d;

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      shadow_q   <= '0;
      ipid_out_q <= '0;
      done_q     <= 1'b0;
      locked_q   <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      shadow_q   <= shadow_d;
      ipid_out_q <= ipid_out_d;
      done_q     <= done_d;
      locked_q   <= locked_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    shadow_d   = shadow_q;
    ipid_out_d = ipid_out_q;
    done_d     = 1'b0;
    locked_d   = locked_q;
    err_d      = 1'b0;
    err_code_d = err_code_q;

    unique case (state_q)
      ST_IDLE: begin
        if (valid && (ipid_chunk == START_WORD)) begin
          state_d = ST_DATA;
          count_d = '0;
        end
      end

      ST_DATA: begin
        if (valid) begin
          // Delimiter values are plain data here; no resync inside a frame
          for (int unsigned i = 0; i < NUM_CHUNKS; i++) begin
            if (count_q == CNT_W'(i)) begin
              shadow_d[i*CHUNK_W +: CHUNK_W] = ipid_chunk;
            end
          end
          if (count_q == CNT_W'(NUM_CHUNKS - 1)) begin
            state_d = ST_STOP;
          end else begin
            count_d = count_q + CNT_W'(1);
          end
        end else begin
          err_d      = 1'b1;
          err_code_d = ERR_GAP;
          state_d    = ST_IDLE;
        end
      end

      ST_STOP: begin
        state_d = ST_IDLE;
        if (!valid) begin
          err_d      = 1'b1;
          err_code_d = ERR_GAP;
        end else if (ipid_chunk == STOP_WORD) begin
          ipid_out_d = shadow_q;
          done_d     = 1'b1;
          locked_d   = 1'b1;
          err_code_d = ERR_NONE;
        end else begin
          err_d      = 1'b1;
          err_code_d = ERR_STOP;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Registered busy tracks the registered state exactly
    busy_d = (state_d != ST_IDLE);
  end

  assign ipid_out    = ipid_out_q;
  assign ipid_done   = done_q;
  assign ipid_locked = locked_q;
  assign busy        = busy_q;
  assign err         = err_q;
  assign err_code    = err_code_q;

`ifdef IPID_RX_COMPARE_EN
  logic match_q, match_d;

  // Compare the completed shadow against the reference on the good-frame edge
  always_comb begin
    match_d = match_q;
    if ((state_q == ST_STOP) && valid && (ipid_chunk == STOP_WORD)) begin
      match_d = (shadow_q == ipid_expected);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      match_q <= 1'b0;
    end else begin
      match_q <= match_d;
    end
  end

  assign ipid_match = match_q;
`endif

endmodule

// File: tb/tb_ipid_stream_rx.sv
// tb_ipid_stream_rx: frame-table driven bench for ipid_stream_rx with a
// per-cycle expected-output scoreboard.
module tb_ipid_stream_rx;

  localparam int unsigned CHUNK_W    = 16;
  localparam int unsigned NUM_CHUNKS = 16;
  localparam int unsigned ID_W       = CHUNK_W * NUM_CHUNKS;
  localparam logic [15:0] START      = 16'h7A7A;
  localparam logic [15:0] STOP       = 16'hB9B9;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              valid = 1'b0;
  logic [15:0]       ipid_chunk = '0;
  logic [ID_W-1:0]   ipid_out;
  logic              ipid_done;
  logic              ipid_locked;
  logic              busy;
  logic              err;
  logic [1:0]        err_code;
`ifdef IPID_RX_COMPARE_EN
  logic [ID_W-1:0]   ipid_expected = '0;
  logic              ipid_match;
`endif

  ipid_stream_rx dut (
    .clk          (clk),
    .rst          (rst),
    .valid        (valid),
    .ipid_chunk   (ipid_chunk),
`ifdef IPID_RX_COMPARE_EN
    .ipid_expected(ipid_expected),
    .ipid_match   (ipid_match),
`endif
    .ipid_out     (ipid_out),
    .ipid_done    (ipid_done),
    .ipid_locked  (ipid_locked),
    .busy         (busy),
    .err          (err),
    .err_code     (err_code)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic            done;
    logic            err;
    logic [1:0]      code;
    logic            busy;
    logic            locked;
    logic [ID_W-1:0] id;
  } exp_t;

  typedef struct {
    int          n_data;
    logic        gap;
    logic [15:0] base;
    logic [15:0] stop;
    int          ovr_idx;
    logic [15:0] ovr_val;
  } frame_t;

  exp_t   sb_q[$];
  exp_t   mon_e;
  frame_t fv[8];

  int n_tests = 0;
  int n_fail  = 0;

  // Frame-level reference state
  logic [ID_W-1:0] m_id     = '0;
  logic            m_locked = 1'b0;
  logic [1:0]      m_code   = 2'b00;

  task automatic chk(input string name, input logic [ID_W-1:0] act, input logic [ID_W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: one expected record per sampled cycle
  always @(posedge clk) begin
    #1;
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      chk("done",     ID_W'(ipid_done),   ID_W'(mon_e.done));
      chk("err",      ID_W'(err),         ID_W'(mon_e.err));
      chk("err_code", ID_W'(err_code),    ID_W'(mon_e.code));
      chk("busy",     ID_W'(busy),        ID_W'(mon_e.busy));
      chk("locked",   ID_W'(ipid_locked), ID_W'(mon_e.locked));
      chk("ipid_out", ipid_out,           mon_e.id);
    end
  end

  task automatic drive(input logic v, input logic [15:0] w, input logic e_done,
                       input logic e_err, input logic e_busy);
    exp_t e;
    @(negedge clk);
    valid      = v;
    ipid_chunk = w;
    e.done   = e_done;
    e.err    = e_err;
    e.code   = m_code;
    e.busy   = e_busy;
    e.locked = m_locked;
    e.id     = m_id;
    sb_q.push_back(e);
  endtask

  task automatic send_frame(input frame_t f);
    logic [ID_W-1:0] id;
    logic [15:0]     w;
    id = '0;
    drive(1'b1, START, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < f.n_data; i++) begin
      w = (i == f.ovr_idx) ? f.ovr_val : f.base + 16'(i);
      id[i*16 +: 16] = w;
      drive(1'b1, w, 1'b0, 1'b0, 1'b1);
    end
    if (f.gap) begin
      m_code = 2'b01;
      drive(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
    end else if (f.stop == STOP) begin
      m_code   = 2'b00;
      m_id     = id;
      m_locked = 1'b1;
      drive(1'b1, f.stop, 1'b1, 1'b0, 1'b0);
    end else begin
      m_code = 2'b10;
      drive(1'b1, f.stop, 1'b0, 1'b1, 1'b0);
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 10 && sb_q.size() != 0; k++) @(negedge clk);
    if (sb_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: got %0d pending want 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  initial begin
    //        n_data gap   base      stop      ovr_idx ovr_val
    fv[0] = '{16, 1'b0, 16'h1000, STOP,     -1, 16'h0000};
    fv[1] = '{5,  1'b1, 16'h2000, STOP,     -1, 16'h0000};
    fv[2] = '{16, 1'b0, 16'h3000, 16'hB9B8, -1, 16'h0000};
    fv[3] = '{16, 1'b0, 16'h1000, STOP,     -1, 16'h0000};
    fv[4] = '{16, 1'b0, 16'h4000, STOP,      3, START};
    fv[5] = '{16, 1'b0, 16'h5000, STOP,     15, STOP};
    fv[6] = '{16, 1'b1, 16'h6000, STOP,     -1, 16'h0000};
    fv[7] = '{16, 1'b0, 16'h1000, STOP,     -1, 16'h0000};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ipid_out", ipid_out, '0);
    chk("rst_flags", ID_W'({ipid_done, ipid_locked, busy, err, err_code}), '0);
    rst = 1'b1;

    // Good, gap, bad stop, recovery (back-to-back frames)
    for (int i = 0; i < 4; i++) send_frame(fv[i]);
    drain();
    chk("id_low_word",  ID_W'(ipid_out[15:0]),    ID_W'(16'h1000));
    chk("id_high_word", ID_W'(ipid_out[255:240]), ID_W'(16'h100F));

    // Noise while idle is ignored
    drive(1'b1, 16'h1234, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 16'h0000, 1'b0, 1'b0, 1'b0);
    drive(1'b1, STOP,     1'b0, 1'b0, 1'b0);

    send_frame(fv[4]);
    drain();
    chk("start_as_data", ID_W'(ipid_out[63:48]), ID_W'(START));
    for (int i = 5; i < 8; i++) send_frame(fv[i]);
    drain();

    // Reset after the 8th data word of a frame
    drive(1'b1, START, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) drive(1'b1, 16'h7000 + 16'(i), 1'b0, 1'b0, 1'b1);
    drain();
    rst   = 1'b0;
    valid = 1'b0;
    #1;
    chk("midrst_ipid_out", ipid_out, '0);
    chk("midrst_flags", ID_W'({ipid_done, ipid_locked, busy, err, err_code}), '0);
    m_id     = '0;
    m_locked = 1'b0;
    m_code   = 2'b00;
    @(negedge clk);
    rst = 1'b1;
    send_frame(fv[0]);
    drain();

`ifdef IPID_RX_COMPARE_EN
    for (int i = 0; i < 16; i++) ipid_expected[i*16 +: 16] = 16'h1000 + 16'(i);
    send_frame(fv[0]);
    drain();
    chk("match_hit", ID_W'(ipid_match), ID_W'(1'b1));
    ipid_expected[0] = ~ipid_expected[0];
    send_frame(fv[0]);
    drain();
    chk("match_miss", ID_W'(ipid_match), ID_W'(1'b0));
`endif

    valid = 1'b0;
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
